weight_load_ctrl: RTL and testbench
===================================

Name: weight_load_ctrl

Overview:
- Sequences the loading of one layer's weights into the weight local memory.
- Accepts 16-bit weight words on a valid/ready stream and drives the memory's write strobe, data, word address, layer-state code and store-done pulse.
- Arbitrates the memory's read enables. Conv and FC read requests are blocked while a layer load is in progress.
- Sits between the top-level DMA/bus slave and the weight local memory.

Parameters:
- L1_WORDS, 216, words per layer-1 load (72 rows x 3 channels)
- L2_WORDS, 576, words per layer-2 load (72 rows x 8 channels)
- L4_WORDS, 576, words per layer-4 load
- L5_WORDS, 576, words per layer-5 load
- L7_WORDS, 400, words per layer-7 load (50 rows x 8 channels)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins a layer load
- load_layer  in  4  layer code sampled with load_start: 0001 L1, 0010 L2, 0011 L4, 0100 L5, 0101 L7
- in_valid  in  1  weight word valid
- in_data  in  16  weight word
- in_ready  out  1  controller accepts word this cycle
- write_weight_signal  out  1  memory write strobe
- write_weight_data  out  16  word to memory
- write_weight_addr  out  16  running word index within the current load
- weight_fsm_cs  out  4  layer-state code to memory
- weight_store_done  out  1  one-cycle pulse when a load completes
- conv_read_req  in  1  conv datapath read request
- fc_read_req  in  1  layer-7 FC read request
- read_weight_signal  out  1  conv read enable (port B)
- layer7_read_weight_signal  out  1  FC read enable (port A)
- busy  out  1  load in progress
- cmd_err  out  1  one-cycle pulse: load_start with an illegal code, or while busy

Behaviour:
- Reset values: all outputs 0; weight_fsm_cs=0000; word counter 0; state IDLE. Reset mid-load aborts immediately with no done pulse.
- Internal states: IDLE, STORE, DRAIN, FINISH.
- weight_fsm_cs mapping:
  - IDLE: 0000
  - STORE and DRAIN: latched layer code
  - FINISH: 1111
- IDLE:
  - load_start with a legal code: latch the code; load N from the matching parameter; clear the counter; go to STORE next cycle.
  - load_start with an illegal code: pulse cmd_err; stay in IDLE.
- STORE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready.
  - On each accept, the next cycle drives write_weight_signal=1, write_weight_data=in_data, write_weight_addr=counter value at accept. Counter then increments.
  - Write latency from accept to strobe is exactly 1 cycle. Back-to-back accepts give back-to-back writes; gaps in in_valid give gaps in writes.
  - Accept of word N-1 moves the state to DRAIN; in_ready=0 from that next cycle.
- DRAIN (1 cycle):
  - Final write is issued here, with weight_fsm_cs still equal to the layer code.
  - Next state is FINISH.
- FINISH (1 cycle):
  - weight_store_done=1; weight_fsm_cs=1111.
  - Next state is IDLE.
- busy=1 in STORE, DRAIN and FINISH.
- load_start while busy: ignored and cmd_err pulsed. The in-progress load is unaffected.
- Read arbitration (combinational):
  - read_weight_signal = conv_read_req && !busy.
  - layer7_read_weight_signal = fc_read_req && !busy.
  - Both may be 1 together, since they drive separate ports.
- write_weight_signal is never 1 in the same cycle as either read enable.
- Counter width is 16 bits. The counter never exceeds N-1 and never wraps within a load.
- in_data is ignored when in_ready=0.

Test Plan:
- Reset, then load_start with code 0001 and 216 continuous valid words (data=index) -> 216 writes at addr 0..215, data matching, each 1 cycle after its accept. Layer code 0001 is held through the last write, then 1111 for one cycle with done=1, then 0000. busy spans from STORE entry through FINISH.
- L7 load (code 0101) with in_valid toggling every other cycle -> exactly 400 writes; in_ready=0 after the 400th accept; done pulses 2 cycles after the last accept.
- conv_read_req=fc_read_req=1 throughout an L2 load -> both read enables 0 while busy and 1 in the cycle after FINISH.
- load_start with code 0110 in IDLE -> cmd_err=1 for 1 cycle, state stays IDLE. load_start code 0010 during an L4 load -> cmd_err pulses; the L4 load completes with 576 writes.
- rst asserted after 100 accepts of an L5 load -> all outputs 0 immediately, no done pulse. A new L5 load afterwards starts at addr 0.
- load_start held together with in_valid in the same cycle -> no word is accepted in that cycle; the first accept occurs in the first STORE cycle.

Source files
------------

// File: rtl/weight_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | weight_load_ctrl : streams one layer's weights into the weight memory and  |
// |                    gates conv/FC memory reads while a load is in flight.    |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module weight_load_ctrl #(
  parameter int L1_WORDS = 216,
  parameter int L2_WORDS = 576,
  parameter int L4_WORDS = 576,
  parameter int L5_WORDS = 576,
  parameter int L7_WORDS = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [3:0]  load_layer,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_data,
  output logic [15:0] write_weight_addr,
  output logic [3:0]  weight_fsm_cs,
  output logic        weight_store_done,
  input  logic        conv_read_req,
  input  logic        fc_read_req,
  output logic        read_weight_signal,
  output logic        layer7_read_weight_signal,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [3:0] C_CS_IDLE   = 4'b0000;
  localparam logic [3:0] C_CS_FINISH = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STORE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  layer_q, layer_d;
  logic [15:0] last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        cmd_err_q, cmd_err_d;

  logic        w_legal;
  logic [15:0] w_words;
  logic        w_accept;

  // Layer code decode: word count for the requested layer, or illegal.
  always_comb begin
    w_legal = 1'b1;
    w_words = 16'd0;
    case (load_layer)
      4'b0001: w_words = 16'(L1_WORDS);
      4'b0010: w_words = 16'(L2_WORDS);
      4'b0011: w_words = 16'(L4_WORDS);
      4'b0100: w_words = 16'(L5_WORDS);
      4'b0101: w_words = 16'(L7_WORDS);
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_STORE);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cmd_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (w_legal) begin
            layer_d = load_layer;
            last_d  = w_words - 16'd1;
            cnt_d   = 16'd0;
            state_d = S_STORE;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_STORE: begin
        if (w_accept) begin
          wr_d      = 1'b1;
          wr_data_d = in_data;
          wr_addr_d = cnt_q;
          // Counter parks on the last index so it never wraps within a load.
          if (cnt_q == last_q) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
    endcase

    if (load_start && (state_q != S_IDLE)) begin
      cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      layer_q   <= 4'd0;
      last_q    <= 16'd0;
      cnt_q     <= 16'd0;
      wr_q      <= 1'b0;
      wr_addr_q <= 16'd0;
      wr_data_q <= 16'd0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    weight_fsm_cs = C_CS_IDLE;
    case (state_q)
      S_STORE, S_DRAIN: weight_fsm_cs = layer_q;
      S_FINISH:         weight_fsm_cs = C_CS_FINISH;
      default:          weight_fsm_cs = C_CS_IDLE;
    endcase
  end

  assign busy                      = (state_q != S_IDLE);
  assign weight_store_done         = (state_q == S_FINISH);
  assign write_weight_signal       = wr_q;
  assign write_weight_addr         = wr_addr_q;
  assign write_weight_data         = wr_data_q;
  assign cmd_err                   = cmd_err_q;
  // Writes only occur while busy, so reads and writes never overlap.
  assign read_weight_signal        = conv_read_req && !busy;
  assign layer7_read_weight_signal = fc_read_req && !busy;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_weight_load_ctrl : scoreboard bench for weight_load_ctrl.               |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [3:0]  load_layer;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        write_weight_signal;
  logic [15:0] write_weight_data;
  logic [15:0] write_weight_addr;
  logic [3:0]  weight_fsm_cs;
  logic        weight_store_done;
  logic        conv_read_req;
  logic        fc_read_req;
  logic        read_weight_signal;
  logic        layer7_read_weight_signal;
  logic        busy;
  logic        cmd_err;

  weight_load_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .load_start                (load_start),
    .load_layer                (load_layer),
    .in_valid                  (in_valid),
    .in_data                   (in_data),
    .in_ready                  (in_ready),
    .write_weight_signal       (write_weight_signal),
    .write_weight_data         (write_weight_data),
    .write_weight_addr         (write_weight_addr),
    .weight_fsm_cs             (weight_fsm_cs),
    .weight_store_done         (weight_store_done),
    .conv_read_req             (conv_read_req),
    .fc_read_req               (fc_read_req),
    .read_weight_signal        (read_weight_signal),
    .layer7_read_weight_signal (layer7_read_weight_signal),
    .busy                      (busy),
    .cmd_err                   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  code;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  rd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [3:0] code, input int idx);
    return 16'(idx) ^ {code, 12'h000};
  endfunction

  // Monitor: every write strobe and done pulse must match the next expectation.
  always @(negedge clk) begin : mon
    wr_t e;
    int  dc;
    if (!rst) begin
      if (write_weight_signal) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(write_weight_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(write_weight_addr), 32'(e.addr));
          chk("wr_data", 32'(write_weight_data), 32'(e.data));
          chk("wr_latency", 32'(cyc), 32'(e.cyc + 1));
          chk("wr_cs", 32'(weight_fsm_cs), 32'(e.code));
          chk("wr_vs_read", 32'({read_weight_signal, layer7_read_weight_signal}), 32'd0);
        end
      end
      if (weight_store_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          dc = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(dc));
          chk("done_cs", 32'(weight_fsm_cs), 32'hF);
        end
      end
    end
  end

  task automatic run_load(input logic [3:0] code, input int n, input bit toggle,
                          input int abort_after, input bit inject);
    int idx = 0;
    int budget = 0;
    int start_cyc;
    @(posedge clk); #1;
    // load_start together with in_valid: nothing may be accepted this cycle.
    load_start = 1'b1;
    load_layer = code;
    in_valid   = 1'b1;
    in_data    = 16'hDEAD;
    @(negedge clk);
    start_cyc = cyc;
    chk("start_in_ready", 32'(in_ready), 32'd0);
    chk("start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    load_start = 1'b0;
    while (idx < n && idx < abort_after && budget < 4 * n + 16) begin
      in_valid   = toggle ? ((budget % 2) == 0) : 1'b1;
      in_data    = word_of(code, idx);
      load_start = inject && (budget == 10);
      load_layer = (inject && budget == 10) ? 4'b0010 : code;
      @(negedge clk);
      chk("store_busy", 32'(busy), 32'd1);
      if (rd_on) chk("store_reads", 32'({read_weight_signal, layer7_read_weight_signal}), 32'd0);
      if (inject && budget == 11) chk("busy_cmd_err_hi", 32'(cmd_err), 32'd1);
      if (inject && budget == 12) chk("busy_cmd_err_lo", 32'(cmd_err), 32'd0);
      if (in_valid && in_ready) begin
        if (idx == 0) chk("first_accept_cycle", 32'(cyc), 32'(start_cyc + 1));
        exp_q.push_back('{cyc: cyc, addr: 16'(idx), data: in_data, code: code});
        idx++;
        if (idx == n) done_q.push_back(cyc + 2);
      end
      budget++;
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    if (idx < n && idx < abort_after) begin
      chk("accept_timeout", 32'(idx), 32'(n));
    end else if (abort_after < n) begin
      rst = 1'b1;
      #1;
      chk("abort_outputs",
          32'({in_ready, write_weight_signal, weight_store_done, busy, cmd_err, weight_fsm_cs}), 32'd0);
      chk("abort_addr_data", {write_weight_addr, write_weight_data}, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      @(negedge clk);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_cs", 32'(weight_fsm_cs), 32'(code));
      chk("drain_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("finish_busy", 32'(busy), 32'd1);
      chk("finish_in_ready", 32'(in_ready), 32'd0);
      if (rd_on) chk("finish_reads", 32'({read_weight_signal, layer7_read_weight_signal}), 32'd0);
      @(negedge clk);
      chk("idle_cs", 32'(weight_fsm_cs), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(weight_store_done), 32'd0);
      if (rd_on) chk("idle_reads", 32'({read_weight_signal, layer7_read_weight_signal}), 32'd3);
    end
  endtask

  initial begin
    rst           = 1'b1;
    load_start    = 1'b0;
    load_layer    = 4'd0;
    in_valid      = 1'b0;
    in_data       = 16'd0;
    conv_read_req = 1'b0;
    fc_read_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl",
        32'({in_ready, write_weight_signal, weight_store_done, busy, cmd_err,
             read_weight_signal, layer7_read_weight_signal}), 32'd0);
    chk("reset_cs", 32'(weight_fsm_cs), 32'd0);
    chk("reset_addr_data", {write_weight_addr, write_weight_data}, 32'd0);
    rst = 1'b0;

    run_load(4'b0001, 216, 1'b0, 1 << 30, 1'b0);
    run_load(4'b0101, 400, 1'b1, 1 << 30, 1'b0);

    conv_read_req = 1'b1;
    fc_read_req   = 1'b1;
    rd_on         = 1'b1;
    @(negedge clk);
    chk("idle_reads_pre", 32'({read_weight_signal, layer7_read_weight_signal}), 32'd3);
    run_load(4'b0010, 576, 1'b0, 1 << 30, 1'b0);
    rd_on         = 1'b0;
    conv_read_req = 1'b0;
    fc_read_req   = 1'b0;

    // Illegal layer code in IDLE.
    @(posedge clk); #1;
    load_start = 1'b1;
    load_layer = 4'b0110;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    chk("illegal_cmd_err_hi", 32'(cmd_err), 32'd1);
    chk("illegal_stays_idle", 32'({busy, weight_fsm_cs}), 32'd0);
    @(negedge clk);
    chk("illegal_cmd_err_lo", 32'(cmd_err), 32'd0);
    chk("illegal_no_store", 32'(in_ready), 32'd0);

    run_load(4'b0011, 576, 1'b0, 1 << 30, 1'b1);
    run_load(4'b0100, 576, 1'b0, 100, 1'b0);
    run_load(4'b0100, 576, 1'b0, 1 << 30, 1'b0);

    repeat (3) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("done_outstanding", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
